uart_echo_ctrl: RTL

Parametrised loopback controller between the UART FIFO interface and board I/O. It pops received words and pushes them back incremented by a constant. It runs in manual mode (one word per debounced button tick) or auto mode (drains the RX FIFO continuously). It counts received words and parity errors, optionally drops erroneous words, and exposes the last received word and status for LED and seven-segment display.

---
 rtl/uart_echo_ctrl_if.sv | 23 ++
 rtl/uart_echo_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl_if.sv
// UART FIFO side of the echo controller: RX pop handshake and TX push handshake.
// master = echo controller, slave = UART FIFO block.
interface uart_echo_ctrl_if #(
  parameter int DBIT = 8
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            error;
  logic            tx_full;
  logic            rd_uart;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;

  modport master (
    input  rx_empty, r_data, error, tx_full,
    output rd_uart, wr_uart, w_data
  );

  modport slave (
    output rx_empty, r_data, error, tx_full,
    input  rd_uart, wr_uart, w_data
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// UART loopback controller: pops RX words, pushes them back incremented by INC.
// Manual mode pops one word per button tick; auto mode drains RX continuously.
// Keeps saturating byte/error counters, a sticky error flag and the last word.
module uart_echo_ctrl #(
  parameter int DBIT  = 8,
  parameter int INC   = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               drop_err,
  input  logic               clr,
  input  logic               btn_tick,
  uart_echo_ctrl_if.master   uart,
  output logic [DBIT-1:0]    last_data,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err_flag,
  output logic               busy
);

  localparam logic [DBIT-1:0] INC_W = DBIT'(INC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t            state_q;
  logic [DBIT-1:0]   last_data_q;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic              pop;

  assign pop = (state_q == POP);

  // Transfer sequencer: trigger decision in IDLE, capture in POP, stall-able push in PUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!uart.rx_empty && (mode || btn_tick)) state_q <= POP;
        end
        POP: begin
          last_data_q <= uart.r_data;
          state_q     <= (drop_err && uart.error) ? IDLE : PUSH;
        end
        PUSH: begin
          if (!uart.tx_full) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counter next-state: clr wins over a same-cycle pop; counts stop at all-ones.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (clr) begin
      byte_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (pop) begin
      if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
      if (uart.error) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        err_flag_d = 1'b1;
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign uart.rd_uart = pop;
  assign uart.wr_uart = (state_q == PUSH) && !uart.tx_full;
  assign uart.w_data  = last_data_q + INC_W;
  assign last_data    = last_data_q;
  assign byte_cnt     = byte_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign err_flag     = err_flag_q;
  assign busy         = (state_q != IDLE);

endmodule
